matmul_drain: RTL
=================

Name: matmul_drain

Overview:
- Result-unload end of the systolic matmul datapath.
- After a start pulse, waits a fixed compute window, then snapshots the N×N accumulator array into a local buffer.
- Streams the snapshot out one row (or column) per beat over a valid/ready interface toward memory or a host bridge.
- Decouples the PE array, which keeps accumulating, from a stalling downstream consumer.

Parameters:
- N, 8, array dimension; must match the upstream mac array.
- WAIT_CYCLES, 3*N-1, clock edges from accepted start to snapshot; must be ≥1.
- IDX_W, $clog2(N) (min 1), width of beat index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a compute/drain sequence; sampled only in IDLE.
- c_in  input  [15:0] x [N][N] unpacked  live accumulator outputs from the array.
- m_valid  output  1  beat valid.
- m_ready  input  1  downstream accept.
- m_data  output  [15:0] x [N] unpacked  one row of the snapshot (column under feature).
- m_index  output  IDX_W  row/column number of current beat.
- m_last  output  1  high on final beat (m_index==N-1).
- busy  output  1  high in WAIT or DRAIN.
- done  output  1  one-cycle pulse after final beat accepted.

Behaviour:
- Reset (async, rst=1): state IDLE; m_valid=0, m_index=0, m_last=0, busy=0, done=0, m_data=0, buffer cleared, wait counter=0. Reset mid-WAIT or mid-DRAIN abandons the sequence; no done pulse.
- States:
  - IDLE: start=1 → WAIT; counter loads WAIT_CYCLES-1; busy=1 next cycle.
  - WAIT: counter decrements each cycle. At counter==0, the same edge captures all of c_in into the buffer, sets m_valid=1 and m_index=0, and enters DRAIN. The snapshot is therefore taken exactly WAIT_CYCLES edges after the start edge.
  - DRAIN: m_data = buffer row m_index, driven from registers and not combinational from c_in.
    - Handshake = m_valid & m_ready.
    - Handshake on a non-final beat increments m_index.
    - Handshake on the final beat: m_valid=0, m_index=0, done=1 for one cycle, busy=0, → IDLE.
- Output stability: while m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable.
- Snapshot isolation: changes on c_in after capture never affect m_data.
- m_ready is ignored when m_valid=0. m_valid never depends combinationally on m_ready.
- start is ignored outside IDLE, including the cycle of the final handshake. A start in the cycle done is high is accepted, since state is then IDLE.
- Width: data passes through unmodified at 16 bits; no arithmetic on the data. Index wraps only via the return to 0 on completion.
- Throughput: one beat per cycle with m_ready held high, so N beats take N cycles. Minimum start-to-done is WAIT_CYCLES+N+1 cycles.

Optional Feature:
- Macro MATMUL_DRAIN_COL_MAJOR_EN.
- Defined: beat k carries column k, i.e. m_data[r] = buffer[r][k] (transposed readout). m_index denotes the column.
- Undefined: beat k carries row k, i.e. m_data[j] = buffer[k][j].
- Timing and handshake are identical in both builds.

Decomposition:
- Package matmul_pkg:
  - DATA_W=16 and typedef word_t (logic [DATA_W-1:0]).
  - enum drain_state_t {IDLE, WAIT, DRAIN}.
- Single module; no sub-module is natural. The wait counter and beat index share one always_ff with the FSM.

Test Plan (N=4, WAIT_CYCLES=11):
- Basic drain: c_in[i][j]=16*i+j held, start pulse, m_ready=1 → first m_valid exactly 11 edges after start. Beats index 0..3 carry {0,1,2,3},{16,17,18,19},{32..35},{48..51}. m_last on index 3; done one cycle later.
- Backpressure: m_ready toggles 1,0,0,1,… → each beat holds stable during stalls, no beat lost or duplicated, exactly 4 handshakes, done once.
- Snapshot isolation: after capture, c_in changes to all 16'hFFFF → drained data still the captured values.
- Start while busy: extra start pulses during WAIT and DRAIN → ignored. Only one sequence runs and the timing is unchanged.
- Reset mid-DRAIN: assert rst after beat 1 → m_valid=0, busy=0, no done. A fresh start then drains from index 0.
- Feature build (MATMUL_DRAIN_COL_MAJOR_EN): same c_in → beat 0 = {0,16,32,48}, beat 3 = {3,19,35,51}.

Source files
------------

// File: rtl/matmul_drain_pkg.sv
// Shared types for the matmul result-unload path.
package matmul_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } drain_state_t;

endpackage

// File: rtl/matmul_drain_if.sv
// Beat stream from the drain unit toward memory or a host bridge.
interface matmul_drain_if #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
);
    import matmul_pkg::*;

    logic             m_valid;
    logic             m_ready;
    word_t            m_data [N];
    logic [IDX_W-1:0] m_index;
    logic             m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/matmul_drain.sv
// Result-unload stage: after start, waits WAIT_CYCLES edges, snapshots the
// N x N accumulator array, then streams one row per beat over valid/ready.
// Build option MATMUL_DRAIN_COL_MAJOR_EN streams columns instead of rows.
module matmul_drain
    import matmul_pkg::*;
#(
    parameter int N           = 8,
    parameter int WAIT_CYCLES = 3 * N - 1,
    parameter int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  word_t c_in [N][N],
    matmul_drain_if.master m,
    output logic  busy,
    output logic  done
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_t     state;
    drain_state_t     state_nx;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    word_t            buffer [N][N];
    logic             hs;
    logic             at_last;

    // Handshake and final-beat qualifiers
    always_comb begin
        hs      = (state == DRAIN) && m.m_ready;
        at_last = (idx == LAST_IDX);
    end

    // State register plus wait counter, beat index, snapshot buffer and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    buffer[r][c] <= '0;
                end
            end
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        idx <= '0;
                        for (int unsigned r = 0; r < N; r++) begin
                            for (int unsigned c = 0; c < N; c++) begin
                                buffer[r][c] <= c_in[r][c];
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (at_last) begin
                            idx  <= '0;
                            done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = DRAIN;
            DRAIN:   if (hs && at_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from registered state; data read from the snapshot only
    always_comb begin
        m.m_valid = (state == DRAIN);
        m.m_index = idx;
        m.m_last  = (state == DRAIN) && at_last;
        busy      = (state != IDLE);
        for (int unsigned j = 0; j < N; j++) begin
            m.m_data[j] = '0;
            if (state == DRAIN) begin
`ifdef MATMUL_DRAIN_COL_MAJOR_EN
                m.m_data[j] = buffer[j][idx];
`else
                m.m_data[j] = buffer[idx][j];
`endif
            end
        end
    end

endmodule
